// File: rtl/cursor_ctrl_multi.sv
// rtl/cursor_ctrl_multi.sv - multi-channel joystick cursor updater with clamp and acceleration
//
// Moves NCH independent cursors one step per rising edge of the rate tick.
// Ports:
//   clk       in   system clock
//   clr_n     in   asynchronous reset, active low
//   tick      in   cursor rate clock (level); rising edge detected internally
//   soft_rst  in   synchronous reinit, wins over a coincident tick edge
//   joy_x/y   in   10*NCH packed joystick samples, channel i at [10i+9:10i]
//   dot_x/y   out  10*NCH packed registered cursor positions
//   moved     out  NCH one-cycle strobes, set when a channel's position changed
module cursor_ctrl_multi #(
    parameter int NCH         = 2,
    parameter int INIT_X      = 204,
    parameter int INIT_Y      = 271,
    parameter int X_LB        = 194,
    parameter int X_UB        = 354,
    parameter int Y_LB        = 71,
    parameter int Y_UB        = 471,
    parameter int LO_FAST     = 150,
    parameter int LO_SLOW     = 400,
    parameter int HI_SLOW     = 600,
    parameter int HI_FAST     = 850,
    parameter int STEP_SLOW   = 10,
    parameter int STEP_FAST   = 20,
    parameter int ACCEL_TICKS = 8
) (
    input  logic                clk,
    input  logic                clr_n,
    input  logic                tick,
    input  logic                soft_rst,
    input  logic [10*NCH-1:0]   joy_x,
    input  logic [10*NCH-1:0]   joy_y,
    output logic [10*NCH-1:0]   dot_x,
    output logic [10*NCH-1:0]   dot_y,
    output logic [NCH-1:0]      moved
);

    localparam int CW = $clog2(ACCEL_TICKS + 1);

    localparam logic [CW-1:0]      ACC_MAX = CW'(ACCEL_TICKS);
    localparam logic [9:0]         LO_F    = 10'(LO_FAST);
    localparam logic [9:0]         LO_S    = 10'(LO_SLOW);
    localparam logic [9:0]         HI_S    = 10'(HI_SLOW);
    localparam logic [9:0]         HI_F    = 10'(HI_FAST);
    localparam logic signed [11:0] SLOW    = 12'(STEP_SLOW);
    localparam logic signed [11:0] FAST1   = 12'(STEP_FAST);
    localparam logic signed [11:0] FAST2   = 12'(2 * STEP_FAST);
    localparam logic signed [11:0] XLB     = 12'(X_LB);
    localparam logic signed [11:0] XUB     = 12'(X_UB);
    localparam logic signed [11:0] YLB     = 12'(Y_LB);
    localparam logic signed [11:0] YUB     = 12'(Y_UB);
    localparam logic [9:0]         IX      = 10'(INIT_X);
    localparam logic [9:0]         IY      = 10'(INIT_Y);

    // Signed step for one axis. low_pos selects whether the low-sample zones
    // push the cursor in the positive direction (X) or negative direction (Y).
    function automatic logic signed [11:0] axis_delta(
        input logic [9:0]         joy,
        input logic signed [11:0] fast,
        input logic               low_pos
    );
        logic signed [11:0] mag;
        logic               low;
        mag = '0;
        low = 1'b0;
        if (joy < LO_F) begin
            mag = fast;
            low = 1'b1;
        end else if (joy < LO_S) begin
            mag = SLOW;
            low = 1'b1;
        end else if (joy > HI_F) begin
            mag = fast;
        end else if (joy > HI_S) begin
            mag = SLOW;
        end
        return (low == low_pos) ? mag : -mag;
    endfunction

    function automatic logic [9:0] clamp(
        input logic signed [11:0] s,
        input logic signed [11:0] lb,
        input logic signed [11:0] ub
    );
        logic signed [11:0] r;
        r = s;
        if (s < lb) r = lb;
        else if (s > ub) r = ub;
        return r[9:0];
    endfunction

    function automatic logic in_fast(input logic [9:0] joy);
        return (joy < LO_F) || (joy > HI_F);
    endfunction

    logic tick_q;
    logic ev;

    // tick_q resets high so a tick already high at release is not an edge.
    assign ev = tick & ~tick_q;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            tick_q <= 1'b1;
        end else if (soft_rst) begin
            tick_q <= 1'b1;
        end else begin
            tick_q <= tick;
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        logic [9:0]         dot_x_q, dot_x_d;
        logic [9:0]         dot_y_q, dot_y_d;
        logic [CW-1:0]      hold_q, hold_d;
        logic               moved_q, moved_d;
        logic [9:0]         jx, jy;
        logic signed [11:0] f_step;
        logic [9:0]         nx, ny;

        assign jx = joy_x[10*g +: 10];
        assign jy = joy_y[10*g +: 10];

        // Boost is chosen from the counter value before this event's increment.
        assign f_step = (hold_q == ACC_MAX) ? FAST2 : FAST1;

        // 12-bit signed sum keeps headroom so the clamp never sees a wrapped value.
        assign nx = clamp($signed({2'b00, dot_x_q}) + axis_delta(jx, f_step, 1'b1), XLB, XUB);
        assign ny = clamp($signed({2'b00, dot_y_q}) + axis_delta(jy, f_step, 1'b0), YLB, YUB);

        always_comb begin
            dot_x_d = dot_x_q;
            dot_y_d = dot_y_q;
            hold_d  = hold_q;
            moved_d = 1'b0;
            if (ev) begin
                dot_x_d = nx;
                dot_y_d = ny;
                moved_d = (nx != dot_x_q) || (ny != dot_y_q);
                if (in_fast(jx) || in_fast(jy)) begin
                    hold_d = (hold_q == ACC_MAX) ? hold_q : hold_q + CW'(1);
                end else begin
                    hold_d = '0;
                end
            end
        end

        always_ff @(posedge clk or negedge clr_n) begin
            if (!clr_n) begin
                dot_x_q <= IX;
                dot_y_q <= IY;
                hold_q  <= '0;
                moved_q <= 1'b0;
            end else if (soft_rst) begin
                dot_x_q <= IX;
                dot_y_q <= IY;
                hold_q  <= '0;
                moved_q <= 1'b0;
            end else begin
                dot_x_q <= dot_x_d;
                dot_y_q <= dot_y_d;
                hold_q  <= hold_d;
                moved_q <= moved_d;
            end
        end

        assign dot_x[10*g +: 10] = dot_x_q;
        assign dot_y[10*g +: 10] = dot_y_q;
        assign moved[g]          = moved_q;
    end

endmodule

// File: tb/tb_cursor_ctrl_multi.sv
// tb/tb_cursor_ctrl_multi.sv - self-checking bench for cursor_ctrl_multi
module tb_cursor_ctrl_multi;

    localparam int NCH = 2;
    localparam int IX = 204, IY = 271;
    localparam int XLB = 194, XUB = 354, YLB = 71, YUB = 471;
    localparam int ACC = 8;

    logic              clk = 1'b0;
    logic              clr_n = 1'b0;
    logic              tick = 1'b1;
    logic              soft_rst = 1'b0;
    logic [10*NCH-1:0] joy_x = '0;
    logic [10*NCH-1:0] joy_y = '0;
    logic [10*NCH-1:0] dot_x;
    logic [10*NCH-1:0] dot_y;
    logic [NCH-1:0]    moved;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    cursor_ctrl_multi dut (
        .clk(clk), .clr_n(clr_n), .tick(tick), .soft_rst(soft_rst),
        .joy_x(joy_x), .joy_y(joy_y),
        .dot_x(dot_x), .dot_y(dot_y), .moved(moved)
    );

    always #5 clk = ~clk;

    // Reference model: positions as plain integers, hold as an event count.
    int mx[NCH] = '{IX, IX};
    int my[NCH] = '{IY, IY};
    int mh[NCH] = '{0, 0};
    bit mm[NCH] = '{0, 0};
    bit m_prev = 1'b1;

    function automatic int x_delta(int joy, int f);
        if (joy < 150) return f;
        if (joy < 400) return 10;
        if (joy > 850) return -f;
        if (joy > 600) return -10;
        return 0;
    endfunction

    function automatic int clampi(int v, int lo, int hi);
        return (v < lo) ? lo : (v > hi) ? hi : v;
    endfunction

    always @(posedge clk or negedge clr_n) begin
        if (!clr_n || soft_rst) begin
            for (int c = 0; c < NCH; c++) begin
                mx[c] = IX; my[c] = IY; mh[c] = 0; mm[c] = 0;
            end
            m_prev = 1'b1;
        end else begin
            bit evm;
            evm = tick && !m_prev;
            m_prev = tick;
            for (int c = 0; c < NCH; c++) begin
                int jx, jy, f, nx, ny;
                bit fz;
                mm[c] = 0;
                if (evm) begin
                    jx = int'(joy_x[10*c +: 10]);
                    jy = int'(joy_y[10*c +: 10]);
                    f  = (mh[c] == ACC) ? 40 : 20;
                    nx = clampi(mx[c] + x_delta(jx, f), XLB, XUB);
                    ny = clampi(my[c] - x_delta(jy, f), YLB, YUB);
                    mm[c] = (nx != mx[c]) || (ny != my[c]);
                    mx[c] = nx;
                    my[c] = ny;
                    fz = (jx < 150) || (jx > 850) || (jy < 150) || (jy > 850);
                    mh[c] = fz ? ((mh[c] < ACC) ? mh[c] + 1 : ACC) : 0;
                end
            end
        end
    end

    // Every-cycle comparison of the DUT against the model.
    always @(negedge clk) begin
        #1;
        if (chk_en) begin
            for (int c = 0; c < NCH; c++) begin
                tests++;
                if (int'(dot_x[10*c +: 10]) != mx[c] || int'(dot_y[10*c +: 10]) != my[c]
                    || moved[c] != mm[c]) begin
                    fails++;
                    $display("FAIL model ch%0d t=%0t: got x=%0d y=%0d mv=%0d want x=%0d y=%0d mv=%0d",
                             c, $time, dot_x[10*c +: 10], dot_y[10*c +: 10], moved[c],
                             mx[c], my[c], mm[c]);
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    function automatic int dx(int c); return int'(dot_x[10*c +: 10]); endfunction
    function automatic int dy(int c); return int'(dot_y[10*c +: 10]); endfunction

    task automatic set_joy(input int c, input int x, input int y);
        joy_x[10*c +: 10] = 10'(x);
        joy_y[10*c +: 10] = 10'(y);
    endtask

    task automatic pulse();
        tick = 1'b0;
        @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
    endtask

    task automatic do_soft_rst();
        set_joy(0, 500, 500);
        set_joy(1, 500, 500);
        @(negedge clk);
        soft_rst = 1'b1;
        @(negedge clk);
        soft_rst = 1'b0;
    endtask

    function automatic int pick_joy();
        int edges[10] = '{0, 149, 150, 399, 400, 600, 601, 850, 851, 1023};
        if ($urandom_range(0, 2) == 0) return edges[$urandom_range(0, 9)];
        return int'($urandom_range(0, 1023));
    endfunction

    initial begin
        set_joy(0, 500, 500);
        set_joy(1, 500, 500);
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        clr_n = 1'b1;
        repeat (3) @(negedge clk);
        for (int c = 0; c < NCH; c++) begin
            check("reset_x", dx(c), 204);
            check("reset_y", dy(c), 271);
            check("reset_mv", int'(moved[c]), 0);
        end

        set_joy(0, 100, 500);
        pulse();
        check("fast_x0", dx(0), 224);
        check("fast_mv0", int'(moved[0]), 1);
        check("ch1_x", dx(1), 204);
        check("ch1_mv", int'(moved[1]), 0);
        @(negedge clk);
        check("mv_pulse", int'(moved[0]), 0);

        do_soft_rst();
        set_joy(0, 300, 500);
        repeat (14) pulse();
        check("slow_x0", dx(0), 344);
        set_joy(0, 100, 500);
        pulse();
        check("clamp_x0", dx(0), 354);
        check("clamp_mv", int'(moved[0]), 1);
        pulse();
        check("pinned_x0", dx(0), 354);
        check("pinned_mv", int'(moved[0]), 0);

        do_soft_rst();
        set_joy(1, 500, 900);
        repeat (8) pulse();
        check("accel8_y1", dy(1), 431);
        pulse();
        check("accel9_y1", dy(1), 471);
        pulse();
        check("accel10_y1", dy(1), 471);
        check("accel10_mv", int'(moved[1]), 0);
        check("indep_y0", dy(0), 271);

        do_soft_rst();
        set_joy(0, 500, 100);
        repeat (8) pulse();
        check("fast8_y0", dy(0), 111);
        set_joy(0, 500, 500);
        pulse();
        check("dead_y0", dy(0), 111);
        set_joy(0, 500, 100);
        pulse();
        check("cleared_y0", dy(0), 91);

        do_soft_rst();
        set_joy(0, 500, 100);
        repeat (8) pulse();
        tick = 1'b0;
        @(negedge clk);
        tick = 1'b1;
        soft_rst = 1'b1;
        @(negedge clk);
        soft_rst = 1'b0;
        check("srst_x0", dx(0), 204);
        check("srst_y0", dy(0), 271);
        check("srst_mv", int'(moved[0]), 0);
        pulse();
        check("srst_hold", dy(0), 251);

        for (int n = 0; n < 4000; n++) begin
            @(negedge clk);
            if ($urandom_range(0, 1) == 0) tick = ~tick;
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(0, 24) == 0) set_joy(c, pick_joy(), pick_joy());
            end
            soft_rst = ($urandom_range(0, 299) == 0);
            if (n == 2000) begin
                clr_n = 1'b0;
                @(negedge clk);
                @(negedge clk);
                clr_n = 1'b1;
            end
        end

        repeat (2) @(negedge clk);
        #2;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
